// File: rtl/vote_sweep_checker.sv
// Stimulus/check engine for the 4-input vote unit: sweeps all 16
// ballots, samples Maj/Uni/Tie after a settle delay, tallies mismatches.
module vote_sweep_checker #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       Maj,
   input  logic       Uni,
   input  logic       Tie,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail,
   output logic       first_fail_valid
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] err_q, err_d;
   logic [3:0] ff_q, ff_d;
   logic       ffv_q, ffv_d;
   logic       pass_q, pass_d;

   logic [2:0] ones;
   logic       exp_maj, exp_uni, exp_tie;
   logic       mism;

   // Reference model of the vote unit for the vector currently driven
   assign ones    = 3'($countones(idx_q));
   assign exp_maj = (ones >= 3'd3);
   assign exp_uni = (ones == 3'd0) || (ones == 3'd4);
   assign exp_tie = (ones == 3'd2);
   assign mism    = {Maj, Uni, Tie} != {exp_maj, exp_uni, exp_tie};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      pass_d  = pass_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = 5'd0;
               ff_d    = 4'd0;
               ffv_d   = 1'b0;
               pass_d  = 1'b0;
               idx_d   = 4'd0;
               cnt_d   = 4'd0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (mism) begin
               err_d = err_q + 5'd1;
               if (!ffv_q) begin
                  ff_d  = idx_q;
                  ffv_d = 1'b1;
               end
            end
            if (idx_q == 4'd15) begin
               // pass must include the verdict on the last vector
               pass_d  = (err_d == 5'd0);
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               cnt_d   = 4'd0;
               state_d = S_SETTLE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         err_q   <= 5'd0;
         ff_q    <= 4'd0;
         ffv_q   <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         pass_q  <= pass_d;
      end
   end

   assign {A, B, C, D}     = idx_q;
   assign busy             = (state_q != S_IDLE);
   assign done             = (state_q == S_DONE);
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_vote_sweep_checker.sv
// Directed bench: behavioural vote unit with injectable faults,
// expected tallies worked out by hand per fault.
module tb_vote_sweep_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       Maj, Uni, Tie;
   logic       A, B, C, D;
   logic       busy, done, pass;
   logic [4:0] err_count;
   logic [3:0] first_fail;
   logic       first_fail_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int fault    = 0;

   vote_sweep_checker #(.SETTLE(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .Maj              (Maj),
      .Uni              (Uni),
      .Tie              (Tie),
      .A                (A),
      .B                (B),
      .C                (C),
      .D                (D),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail       (first_fail),
      .first_fail_valid (first_fail_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vote unit under check; fault 1: Tie stuck 0, 2: Uni stuck 1, 3: Maj inverted
   always_comb begin
      int k;
      k = int'(A) + int'(B) + int'(C) + int'(D);
      Maj = (k >= 3);
      Uni = (k == 0) || (k == 4);
      Tie = (k == 2);
      if (fault == 1) Tie = 1'b0;
      if (fault == 2) Uni = 1'b1;
      if (fault == 3) Maj = ~Maj;
   end

   task automatic check(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      check({tag, "_abcd"}, int'({A, B, C, D}), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pass"}, int'(pass), 0);
      check({tag, "_err"}, int'(err_count), 0);
      check({tag, "_ff"}, int'(first_fail), 0);
      check({tag, "_ffv"}, int'(first_fail_valid), 0);
   endtask

   task automatic sweep(input int mode_v, input int exp_err,
                        input int exp_ff, input int exp_pass,
                        input int restart_at, input int abort_at,
                        input bit chk_vec);
      int lat;
      fault = mode_v;
      lat   = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 0; n < 200; n++) begin
         start = (n == restart_at);
         if (n == 0) check("busy_rise", int'(busy), 1);
         if (n == 1) begin
            check("clr_pass", int'(pass), 0);
            check("clr_err", int'(err_count), 0);
            check("clr_ffv", int'(first_fail_valid), 0);
         end
         if (chk_vec && n < 80 && (n % 5 == 0 || n % 5 == 4))
            check("vec", int'({A, B, C, D}), n / 5);
         if (n == abort_at) begin
            check("pre_rst_err", int'(err_count), 3);
            rst_n = 1'b0;
            #1;
            chk_reset_vals("rst_mid");
            for (int j = 0; j < 3; j++) begin
               @(posedge clk);
               #1;
               check("rst_no_done", int'(done), 0);
            end
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("latency", lat, 80);
      check("pass", int'(pass), exp_pass);
      check("err_count", int'(err_count), exp_err);
      check("first_fail", int'(first_fail), exp_ff);
      check("ffv", int'(first_fail_valid), (exp_err != 0) ? 1 : 0);
      check("hold_abcd", int'({A, B, C, D}), 15);
      @(posedge clk);
      #1;
      check("busy_fall", int'(busy), 0);
      check("done_pulse", int'(done), 0);
      check("pass_hold", int'(pass), exp_pass);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      sweep(0, 0, 0, 1, -1, -1, 1'b1);
      sweep(1, 6, 3, 0, -1, -1, 1'b0);
      sweep(2, 14, 1, 0, -1, -1, 1'b0);
      sweep(3, 16, 0, 0, -1, -1, 1'b0);
      sweep(0, 0, 0, 1, 36, -1, 1'b1);
      sweep(1, 6, 3, 0, -1, 47, 1'b0);
      sweep(0, 0, 0, 1, -1, -1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vote_sweep_checker.md
# vote_sweep_checker

Self-checking stimulus engine for the 4-input vote unit (majority / unanimous / tie decoder). On `start` it walks all 16 ballot vectors onto `A,B,C,D`, waits a settle interval, samples the unit's `Maj`, `Uni` and `Tie` outputs, and compares them against its own reference model. It sits on the board between the push-button/switch front end and the vote unit, and reports pass/fail, error count and the first failing vector on LEDs.

## Interface
- `SETTLE`, default 4: cycles a vector is held before sampling; legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled level; starts a sweep when not busy.
- `Maj`, `Uni`, `Tie`  in  1 each  outputs of the vote unit under check.
- `A`, `B`, `C`, `D`  out  1 each  ballot vector driven to the vote unit; `A` is the MSB of the index.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  high after a sweep with zero mismatches; held until next start.
- `err_count`  out  5  number of mismatching vectors, 0..16.
- `first_fail`  out  4  index of the first mismatching vector.
- `first_fail_valid`  out  1  high once any mismatch has been recorded in this sweep.

## Operation
- Reference model, where n = number of ones in {A,B,C,D}: `Maj`=(n>=3), `Uni`=(n==0 or n==4), `Tie`=(n==2).
- A vector counts as a mismatch if any of the three bits differs; one mismatch adds at most 1 to `err_count`.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: `busy`=0. `start`=1 -> clear `err_count`, `first_fail`, `first_fail_valid` and `pass`; set idx=0 and `{A,B,C,D}`=0; settle counter=0; go to SETTLE.
- SETTLE: increment the settle counter each cycle. When counter==SETTLE-1, go to CHECK.
- CHECK: compare the sampled inputs to the model for idx.
  - On mismatch: increment `err_count`. If `first_fail_valid`=0, set `first_fail`=idx and `first_fail_valid`=1.
  - If idx==15, go to DONE.
  - Otherwise idx+1, drive the new vector, clear the settle counter, and go to SETTLE.
- DONE: `done`=1 for this single cycle. `pass` is set to (`err_count`==0), using the final value that includes the idx-15 check. Then go to IDLE.
- `start` is ignored in SETTLE, CHECK and DONE. If `start` is still high in IDLE after DONE, a new sweep starts; this gives continuous sweeping when `start` is tied high.
- After a sweep, `{A,B,C,D}` holds 4'b1111 until the next start or reset.
- `err_count` needs no saturation: 5 bits covers the maximum of 16.

## Timing
- Reset, asynchronous: state=IDLE, `{A,B,C,D}`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_fail_valid`=0, idx=0, settle counter=0.
- Reset asserted mid-sweep aborts the sweep immediately. No `done` is produced and all results return to their reset values.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in CHECK. The vote unit's inputs are stable for SETTLE full cycles before sampling.
- Let E0 be the clock edge that accepts `start`.
  - `busy` rises at E0.
  - Vector k is driven from edge E0+k·(SETTLE+1).
  - It is sampled at edge E0+(k+1)·(SETTLE+1)−1+1, i.e. the CHECK cycle.
  - `done` is high in the cycle after edge E0+16·(SETTLE+1).
  - `busy` falls with `done` leaving, together with the return to IDLE.
- Total sweep with default SETTLE=4 is 80 cycles from E0 to `done`.
- `err_count` and `first_fail` update on the CHECK edge of the failing vector.

## Test plan
- Correct behavioural vote unit, SETTLE=4, `start` pulsed for 1 cycle:
  - `done` arrives exactly 80 cycles after the accepting edge.
  - `pass`=1, `err_count`=0, `first_fail_valid`=0.
  - `{A,B,C,D}` steps 0..15, each held for 5 cycles.
- `Tie` stuck at 0:
  - `err_count`=6 (vectors 3,5,6,9,10,12).
  - `first_fail`=3, `first_fail_valid`=1, `pass`=0.
- `Uni` stuck at 1:
  - `err_count`=14.
  - `first_fail`=1, `pass`=0.
- `Maj` inverted:
  - `err_count`=16.
  - `first_fail`=0, `pass`=0.
- `start` re-pulsed mid-sweep at vector 7:
  - The pulse is ignored and the sweep completes on the original schedule.
  - A following start clears the results and `pass` returns to 0 until the new `done`.
- `rst_n` low during vector 9 of a failing sweep:
  - All outputs go to their reset values immediately and no `done` pulse occurs.
  - After release with `start`=1, a full sweep restarts from vector 0.
